// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the memory-op arbiter. Holds the
//               resend entry field positions, message type codes, request
//               word bit indices, the core count and the arbiter state type.
// Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   localparam int nCores = 16;

   // Resend entry layout: {dest[39:36], type[35:32], payload[31:0]}
   localparam int resendDestMsb    = 39;
   localparam int resendDestLsb    = 36;
   localparam int resendTypeMsb    = 35;
   localparam int resendTypeLsb    = 32;
   localparam int resendPayloadMsb = 31;

   // Message type codes carried in the resend entry type field
   localparam logic [3:0] typeAddress        = 4'h1;
   localparam logic [3:0] typeGrantExclusive = 4'h2;

   // Request word bit indices
   localparam int reqReadBit      = 28;
   localparam int reqExclusiveBit = 29;
   localparam int reqRetryBit     = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA_1 = 2'd1,
      DATA_2 = 2'd2
   } arbState_t;

   function automatic logic isAddressEntry(input logic [39:0] entry);
      return entry[resendTypeMsb:resendTypeLsb] == typeAddress;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_holdoff.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_holdoff
// Description : Loadable saturating down-counter. Counts down by one every
//               cycle while non-zero; a load takes priority over counting.
// Ports       : clock, reset (async active-low), load, loadValue[WIDTH-1:0],
//               isZero (registered count equals zero)
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb_holdoff #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   output logic             isZero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   // Decoded from the registered count, so a resend becomes eligible the
   // cycle after the counter reaches zero.
   assign isZero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_op_arbiter
// Description : Merges fresh ring requests and resend-queue entries into the
//               memory-op queue and write-data queue. Fresh flushes are
//               followed atomically by two 128-bit data beats. Resent Address
//               ops are spaced by a holdoff counter; other resent types go to
//               the grant return path untouched. Fresh grants are limited to
//               FRESH_BURST in a row while resends are waiting.
// Ports       : clock, reset (async active-low)
//               reqValid/reqReady/reqDest/reqData     fresh requests
//               wdValid/wdReady/wdData                flush data beats
//               resendEmpty/rdResend/resendIn         resend queue pop side
//               memOpQfull/wrMemOp/memOpDestOut/memOpDataOut
//               writeDataQfull/wrWriteData/writeDataOut
//               grantFull/wrGrant/grantOut
//               statResends/statOps (only with MEM_ARB_STATS_EN defined)
// Options     : MEM_ARB_STATS_EN adds wrapping pop/op event counters.
// Revision    : 1.0  initial release
// ============================================================================
module mem_op_arbiter
   import mem_arb_pkg::*;
#(
   parameter int RETRY_DELAY = 16,
   parameter int FRESH_BURST = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         reqValid,
   output logic         reqReady,
   input  logic [3:0]   reqDest,
   input  logic [31:0]  reqData,
   input  logic         wdValid,
   output logic         wdReady,
   input  logic [127:0] wdData,
   input  logic         resendEmpty,
   output logic         rdResend,
   input  logic [39:0]  resendIn,
   input  logic         memOpQfull,
   output logic         wrMemOp,
   output logic [3:0]   memOpDestOut,
   output logic [31:0]  memOpDataOut,
   input  logic         writeDataQfull,
   output logic         wrWriteData,
   output logic [127:0] writeDataOut,
   input  logic         grantFull,
   output logic         wrGrant,
   output logic [39:0]  grantOut
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]  statResends,
   output logic [31:0]  statOps
`endif
);

   localparam logic [7:0] retryDelayValue = 8'(RETRY_DELAY);
   localparam logic [3:0] burstLimit      = 4'(FRESH_BURST);

   arbState_t  state, nextState;
   logic [3:0] burst, burstNext, freshBurstNext;
   logic       holdoffLoad, holdoffZero;
   logic       resendIsAddr, resendEligible, resendWins;

   mem_arb_holdoff #(
      .WIDTH (8)
   ) holdoff (
      .clock     (clock),
      .reset     (reset),
      .load      (holdoffLoad),
      .loadValue (retryDelayValue),
      .isZero    (holdoffZero)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         burst <= '0;
      end else begin
         state <= nextState;
         burst <= burstNext;
      end
   end

   always_comb begin
      reqReady     = 1'b0;
      wdReady      = 1'b0;
      rdResend     = 1'b0;
      wrMemOp      = 1'b0;
      memOpDestOut = '0;
      memOpDataOut = '0;
      wrWriteData  = 1'b0;
      writeDataOut = '0;
      wrGrant      = 1'b0;
      grantOut     = '0;
      holdoffLoad  = 1'b0;
      nextState    = state;
      burstNext    = burst;

      resendIsAddr   = isAddressEntry(resendIn);
      resendEligible = ~resendEmpty & (~resendIsAddr | holdoffZero);
      resendWins     = resendEligible & ((burst == burstLimit) | ~reqValid);

      // Fresh grants only count toward the burst limit while resends wait;
      // an empty resend queue restarts the streak.
      if (resendEmpty) begin
         freshBurstNext = '0;
      end else if (burst == burstLimit) begin
         freshBurstNext = burst;
      end else begin
         freshBurstNext = burst + 4'd1;
      end

      // Outputs are forced low while reset is held so nothing is popped or
      // written during an asynchronous reset.
      if (reset) begin
         unique case (state)
            IDLE: begin
               if (resendWins) begin
                  // A winning resend blocked by a full queue stalls rather
                  // than letting a fresh request slip past it.
                  if (resendIsAddr) begin
                     if (!memOpQfull) begin
                        wrMemOp      = 1'b1;
                        memOpDestOut = resendIn[resendDestMsb:resendDestLsb];
                        memOpDataOut = resendIn[resendPayloadMsb:0];
                        rdResend     = 1'b1;
                        holdoffLoad  = 1'b1;
                        burstNext    = '0;
                     end
                  end else if (!grantFull) begin
                     wrGrant   = 1'b1;
                     grantOut  = resendIn;
                     rdResend  = 1'b1;
                     burstNext = '0;
                  end
               end else if (reqValid) begin
                  if (reqData[reqReadBit]) begin
                     if (!memOpQfull) begin
                        wrMemOp      = 1'b1;
                        memOpDestOut = reqDest;
                        memOpDataOut = reqData;
                        reqReady     = 1'b1;
                        burstNext    = freshBurstNext;
                     end
                  end else if (!memOpQfull && !writeDataQfull) begin
                     // Flush op; its two beats follow before anything else.
                     wrMemOp      = 1'b1;
                     memOpDestOut = reqDest;
                     memOpDataOut = reqData;
                     reqReady     = 1'b1;
                     burstNext    = freshBurstNext;
                     nextState    = DATA_1;
                  end
               end
            end
            DATA_1, DATA_2: begin
               if (wdValid && !writeDataQfull) begin
                  wdReady      = 1'b1;
                  wrWriteData  = 1'b1;
                  writeDataOut = wdData;
                  nextState    = (state == DATA_1) ? DATA_2 : IDLE;
               end
            end
            default: nextState = IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         statResends <= '0;
         statOps     <= '0;
      end else begin
         if (rdResend) statResends <= statResends + 32'd1;
         if (wrMemOp)  statOps     <= statOps + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_op_arbiter
// Description : Self-checking bench for mem_op_arbiter. Source FIFOs model
//               the request, data-beat and resend queues; expected queue
//               writes are pushed when stimulus is issued and a monitor pops
//               and compares them whenever the DUT writes a queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_op_arbiter;
   import mem_arb_pkg::*;

   localparam int RETRY_DELAY = 16;
   localparam int FRESH_BURST = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic         reqValid, reqReady;
   logic [3:0]   reqDest;
   logic [31:0]  reqData;
   logic         wdValid, wdReady;
   logic [127:0] wdData;
   logic         resendEmpty, rdResend;
   logic [39:0]  resendIn;
   logic         memOpQfull, wrMemOp;
   logic [3:0]   memOpDestOut;
   logic [31:0]  memOpDataOut;
   logic         writeDataQfull, wrWriteData;
   logic [127:0] writeDataOut;
   logic         grantFull, wrGrant;
   logic [39:0]  grantOut;
`ifdef MEM_ARB_STATS_EN
   logic [31:0]  statResends, statOps;
`endif

   always #5 clock = ~clock;

   mem_op_arbiter #(
      .RETRY_DELAY (RETRY_DELAY),
      .FRESH_BURST (FRESH_BURST)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .reqValid       (reqValid),
      .reqReady       (reqReady),
      .reqDest        (reqDest),
      .reqData        (reqData),
      .wdValid        (wdValid),
      .wdReady        (wdReady),
      .wdData         (wdData),
      .resendEmpty    (resendEmpty),
      .rdResend       (rdResend),
      .resendIn       (resendIn),
      .memOpQfull     (memOpQfull),
      .wrMemOp        (wrMemOp),
      .memOpDestOut   (memOpDestOut),
      .memOpDataOut   (memOpDataOut),
      .writeDataQfull (writeDataQfull),
      .wrWriteData    (wrWriteData),
      .writeDataOut   (writeDataOut),
      .grantFull      (grantFull),
      .wrGrant        (wrGrant),
      .grantOut       (grantOut)
`ifdef MEM_ARB_STATS_EN
      ,
      .statResends    (statResends),
      .statOps        (statOps)
`endif
   );

   // Source FIFOs
   logic [35:0]  reqMem [0:127];
   logic [127:0] wdMem  [0:127];
   logic [39:0]  rsMem  [0:127];
   int reqHead = 0, reqTail = 0, wdHead = 0, wdTail = 0, rsHead = 0, rsTail = 0;
   bit reqPop = 0, wdPop = 0, rsPop = 0;

   assign reqValid    = (reqHead != reqTail);
   assign reqDest     = reqMem[reqHead][35:32];
   assign reqData     = reqMem[reqHead][31:0];
   assign wdValid     = (wdHead != wdTail);
   assign wdData      = wdMem[wdHead];
   assign resendEmpty = (rsHead == rsTail);
   assign resendIn    = rsMem[rsHead];

   // Scoreboard
   logic [35:0]  expMemOp [$];
   logic [127:0] expWd    [$];
   logic [39:0]  expGrant [$];
   int           memOpCycles [$];
   bit           trace [$];     // 0 = fresh grant, 1 = resend grant
   bit           traceOn = 0;
   int           cycle = 0;
   int           nChecks = 0, nPass = 0;

   task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
   endtask

   task automatic failNow(input string name);
      nChecks++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [209:0] outVec();
      return {reqReady, wdReady, rdResend, wrMemOp, memOpDestOut, memOpDataOut,
              wrWriteData, writeDataOut, wrGrant, grantOut};
   endfunction

   // Monitor: compares every queue write against the expected queues.
   always @(negedge clock) begin
      reqPop = reqReady;
      wdPop  = wdReady;
      rsPop  = rdResend;
      if (wrMemOp) begin
         memOpCycles.push_back(cycle);
         if (expMemOp.size() == 0) failNow("memOp unexpected write");
         else check("memOp", {memOpDestOut, memOpDataOut}, expMemOp.pop_front());
      end
      if (wrWriteData) begin
         if (expWd.size() == 0) failNow("writeData unexpected write");
         else check("writeData", writeDataOut, expWd.pop_front());
      end
      if (wrGrant) begin
         if (expGrant.size() == 0) failNow("grant unexpected write");
         else check("grant", grantOut, expGrant.pop_front());
      end
      if (traceOn) begin
         if (reqReady) trace.push_back(1'b0);
         if (rdResend) trace.push_back(1'b1);
      end
   end

   // Apply pops seen at the preceding negedge just after the clock edge.
   always @(posedge clock) begin
      cycle++;
      #1;
      if (reqPop) reqHead++;
      if (wdPop)  wdHead++;
      if (rsPop)  rsHead++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic pushRead(input logic [3:0] dest, input logic [31:0] data);
      reqMem[reqTail] = {dest, data};
      reqTail++;
      expMemOp.push_back({dest, data});
   endtask

   task automatic pushBeat(input logic [127:0] beat, input bit expected);
      wdMem[wdTail] = beat;
      wdTail++;
      if (expected) expWd.push_back(beat);
   endtask

   task automatic pushResend(input logic [39:0] entry);
      rsMem[rsTail] = entry;
      rsTail++;
      if (entry[35:32] == typeAddress) expMemOp.push_back({entry[39:36], entry[31:0]});
      else expGrant.push_back(entry);
   endtask

   task automatic waitDrained(input int budget, input string name);
      bit done = 0;
      for (int i = 0; i < budget; i++) begin
         if (expMemOp.size() == 0 && expWd.size() == 0 && expGrant.size() == 0 &&
             reqHead == reqTail && rsHead == rsTail) begin
            done = 1;
            break;
         end
         tick(1);
      end
      if (!done) failNow({name, " timeout"});
   endtask

   task automatic waitNeg(input int which, input int budget, input string name);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if ((which == 0 && reqReady) || (which == 1 && wrWriteData) || (which == 2 && wrGrant)) begin
            seen = 1;
            break;
         end
      end
      if (!seen) failNow({name, " timeout"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      bit expBit;
      for (int i = 0; i < 128; i++) begin
         reqMem[i] = '0;
         wdMem[i]  = '0;
         rsMem[i]  = '0;
      end
      reset = 1'b0;
      memOpQfull = 1'b0;
      writeDataQfull = 1'b0;
      grantFull = 1'b0;

      // Reset state with a request already waiting
      tick(2);
      pushRead(4'd2, 32'h1000_0040);
      @(negedge clock);
      check("reset outputs", outVec(), '0);
      @(posedge clock); #2;
      reset = 1'b1;
      @(negedge clock);
      check("fresh read same cycle", {reqReady, wrMemOp}, 2'b11);

      // Flush with write-data queue full for 3 cycles in DATA_1
      tick(1);
      pushRead(4'd5, 32'h2000_0080);
      pushBeat({4{32'hAAAA_0001}}, 1);
      pushBeat({4{32'hBBBB_0002}}, 1);
      waitNeg(0, 10, "flush op");
      @(posedge clock); #2;
      writeDataQfull = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("flush stall", {wdReady, wrWriteData}, 2'b00);
      end
      @(posedge clock); #2;
      writeDataQfull = 1'b0;
      pushBeat({4{32'hCCCC_0003}}, 0);
      waitDrained(20, "flush beats");
      tick(3);
      check("stray beat untouched", wdTail - wdHead, 1);
      @(negedge clock);
      check("idle wdReady", wdReady, 1'b0);
      @(posedge clock); #2;
      wdHead = wdTail;

      // Two Address resends spaced by the holdoff
      memOpCycles.delete();
      pushResend({4'd3, typeAddress, 32'h9000_0100});
      pushResend({4'd4, typeAddress, 32'h9000_0200});
      waitDrained(60, "address resends");
      check("address resend count", memOpCycles.size(), 2);
      if (memOpCycles.size() == 2)
         check("address resend spacing", memOpCycles[1] - memOpCycles[0], RETRY_DELAY + 1);

      // GrantExclusive resend bypasses a full memory-op queue
      memOpQfull = 1'b1;
      pushResend({4'd7, typeGrantExclusive, 32'h1234_5678});
      waitNeg(2, 10, "grant resend");
      check("grant without memOp", wrMemOp, 1'b0);
      @(posedge clock); #2;
      memOpQfull = 1'b0;
      waitDrained(10, "grant drain");

      // Burst limiting: 20 fresh reads against 12 waiting grant resends
      trace.delete();
      traceOn = 1;
      for (int i = 0; i < 12; i++) pushResend({4'(i), typeGrantExclusive, 32'hA000_0000 + 32'(i)});
      for (int i = 0; i < 20; i++) pushRead(4'(i % 16), 32'h1000_0000 + 32'(i * 4));
      waitDrained(200, "burst");
      traceOn = 0;
      check("burst trace length", trace.size(), 32);
      bad = 0;
      for (int k = 0; k < trace.size(); k++) begin
         expBit = (k < 25) ? ((k % 5) == 4) : 1'b1;
         if (trace[k] != expBit) bad++;
      end
      check("burst pattern mismatches", bad, 0);

      // Reset while in DATA_2
      tick(1);
      pushRead(4'd9, 32'h2000_0100);
      pushBeat({4{32'hDDDD_0004}}, 1);
      waitNeg(1, 10, "first beat");
      @(posedge clock); #2;
      pushBeat({4{32'hEEEE_0005}}, 0);
      reset = 1'b0;
      #1;
      check("reset in DATA_2 outputs", outVec(), '0);
      tick(2);
      wdHead = wdTail;
      reset = 1'b1;
      pushBeat({4{32'hFFFF_0006}}, 0);
      @(negedge clock);
      check("idle after reset", wdReady, 1'b0);
      @(posedge clock); #2;
      wdHead = wdTail;
      pushRead(4'd11, 32'h1000_0400);
      @(negedge clock);
      check("read after reset", {reqReady, wrMemOp}, 2'b11);
      waitDrained(10, "final");
`ifdef MEM_ARB_STATS_EN
      check("stats after reset", {statOps, statResends}, {32'd1, 32'd0});
`endif
      check("scoreboard drained", expMemOp.size() + expWd.size() + expGrant.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
